count_capture_unit: RTL and testbench
=====================================

// Module: count_capture_unit
// PURPOSE
//   Input-capture stage that sits downstream of n_bit_counter. It consumes the
//   free-running count bus and timestamps edges of an asynchronous event input.
//   Each qualifying edge pushes {edge direction, count} into a small FWFT FIFO.
//   Software/downstream logic drains the FIFO over a valid/ready handshake.
// PARAMETERS
//   N      7   count MSB index; count and cap_data are N+1 bits wide (matches counter)
//   DEPTH  4   FIFO entries, power of two, >= 2
//   LW     3   fifo_level width; must equal clog2(DEPTH+1)
// PORTS
//   clk         in   1     clock, posedge-active (counter updates on negedge, so count is stable here)
//   clr         in   1     reset, asynchronous, active-high
//   count       in   N+1   timestamp bus from the upstream counter
//   evt_in      in   1     asynchronous event input
//   edge_sel    in   2     00 off, 01 rising, 10 falling, 11 both
//   cap_ready   in   1     consumer accepts the head entry
//   ovf_clr     in   1     clears the sticky overflow flag
//   cap_valid   out  1     FIFO non-empty; head entry is on cap_data/cap_edge
//   cap_data    out  N+1   captured count at FIFO head
//   cap_edge    out  1     1 = rising edge captured, 0 = falling edge captured
//   fifo_level  out  LW    number of entries held, 0..DEPTH
//   overflow    out  1     sticky: a capture was dropped because the FIFO was full
// BEHAVIOUR
//   Reset (clr=1, async): all flops go to 0.
//     cap_valid=0, cap_data=0, cap_edge=0, fifo_level=0, overflow=0.
//     FSM=WARMUP, warm-up counter=0, evt_s1/evt_s2/evt_d=0.
//   Synchroniser: evt_s1<=evt_in; evt_s2<=evt_s1; evt_d<=evt_s2 (all on posedge clk).
//     rise = evt_s2 & ~evt_d; fall = ~evt_s2 & evt_d.
//   FSM:
//     WARMUP: 2-bit counter increments each cycle; no pushes. Move to RUN on the
//       cycle the counter reaches 3. This suppresses the false edge when evt_in
//       is high at reset release.
//     RUN: capture enabled; stays in RUN until clr.
//   Push condition (RUN only): (rise & edge_sel[0]) | (fall & edge_sel[1]).
//     On that posedge, write {rise, count} into the FIFO. count is sampled at
//     that same posedge.
//   Latency: evt_in settles before posedge t0 -> push at posedge t0+2 ->
//     cap_valid=1 after t0+2.
//   edge_sel is sampled each cycle with no latching. A change applies to the
//     next push decision.
//   FIFO: first-word fall-through; cap_data/cap_edge are valid whenever cap_valid=1.
//     Pop occurs when cap_valid & cap_ready at posedge.
//     cap_ready while empty: ignored, no state change.
//   Push and pop in the same cycle:
//     not full: level unchanged, both take effect.
//     full: pop frees a slot, push is accepted, no overflow.
//     empty: entry is written; cap_valid rises next cycle (no bypass).
//   Push when full with no pop: entry is discarded, FIFO contents unchanged,
//     overflow<=1.
//   overflow: cleared by ovf_clr. If a drop and ovf_clr happen in the same
//     cycle, set wins (overflow=1).
//   Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is stored as-is;
//     counter wrap (all-ones -> 0) needs no special handling.
//   clr mid-operation: FIFO is flushed, captures in flight are lost, FSM
//     returns to WARMUP.
// TESTING
//   1 evt_in held 1 through reset, edge_sel=01, release clr -> no capture;
//     cap_valid stays 0 for 20 cycles.
//   2 edge_sel=01, count=8'h10 at detect posedge, evt_in 0->1 -> cap_valid
//     after 3 posedges; cap_data=8'h10, cap_edge=1, fifo_level=1.
//   3 edge_sel=11, evt_in pulse 1 for 5 cycles, cap_ready=1 ->
//     2 entries, cap_edge 1 then 0, cap_data differs by 5.
//   4 cap_ready=0, 5 rising edges, DEPTH=4 -> fifo_level=4, overflow=1,
//     first 4 timestamps retained in order; ovf_clr=1 -> overflow=0.
//   5 FIFO full, push and pop in same cycle -> fifo_level stays 4, overflow
//     stays 0, oldest entry removed.
//   6 clr pulse while fifo_level=3 -> cap_valid=0, fifo_level=0 immediately
//     (async); edges in the next 3 cycles are ignored.

Source files
------------

// File: rtl/count_capture_unit.sv
// Purpose: timestamps synchronised edges of evt_in with the upstream count and queues {edge, count} in a FWFT FIFO.
// Latency: evt_in stable before posedge t0 -> entry written at t0+2 -> cap_valid high after t0+2.
// Backpressure: valid/ready drain; a capture that meets a full FIFO with no pop is dropped and sets sticky overflow.
module count_capture_unit #(
  parameter int N     = 7,
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [N:0]    count,
  input  logic          evt_in,
  input  logic [1:0]    edge_sel,
  input  logic          cap_ready,
  input  logic          ovf_clr,
  output logic          cap_valid,
  output logic [N:0]    cap_data,
  output logic          cap_edge,
  output logic [LW-1:0] fifo_level,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {WARMUP = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [1:0]    warm_cnt;
  logic          evt_s1, evt_s2, evt_d;
  logic          rise, fall;
  logic          cap_en;
  logic          push, pop, full, wr_en, drop;
  logic [N+1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  // Two-flop synchroniser plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      evt_s1 <= 1'b0;
      evt_s2 <= 1'b0;
      evt_d  <= 1'b0;
    end else begin
      evt_s1 <= evt_in;
      evt_s2 <= evt_s1;
      evt_d  <= evt_s2;
    end
  end

  assign rise = evt_s2 & ~evt_d;
  assign fall = ~evt_s2 & evt_d;

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= WARMUP;
    else     state <= state_nxt;
  end

  // Warm-up counter: runs only while warming up, freezes once in RUN.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                  warm_cnt <= 2'd0;
    else if (state == WARMUP) warm_cnt <= warm_cnt + 2'd1;
  end

  // Next state: enter RUN on the edge where the warm-up counter becomes 3,
  // which masks the spurious rise seen when evt_in is high at reset release.
  always_comb begin
    state_nxt = state;
    case (state)
      WARMUP:  if (warm_cnt == 2'd2) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = WARMUP;
    endcase
  end

  // FSM output: capture is only enabled in RUN.
  always_comb begin
    cap_en = 1'b0;
    if (state == RUN) cap_en = 1'b1;
  end

  assign push  = cap_en & ((rise & edge_sel[0]) | (fall & edge_sel[1]));
  assign pop   = cap_valid & cap_ready;
  assign full  = (fifo_level == LW'(DEPTH));
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // FIFO storage and pointers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) begin
        mem[wptr] <= {rise, count};
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
    end
  end

  // Occupancy count.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fifo_level <= '0;
    end else begin
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as ovf_clr keeps it set.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  assign cap_valid = (fifo_level != '0);
  assign cap_data  = mem[rptr][N:0];
  assign cap_edge  = mem[rptr][N+1];

endmodule

// File: tb/tb_count_capture_unit.sv
module tb_count_capture_unit;

  localparam int N     = 7;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic [N:0]    count = '0;
  logic          evt_in = 1'b0;
  logic [1:0]    edge_sel = 2'b01;
  logic          cap_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          cap_valid;
  logic [N:0]    cap_data;
  logic          cap_edge;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  int n_chk  = 0;
  int n_pass = 0;

  count_capture_unit #(.N(N), .DEPTH(DEPTH), .LW(LW)) dut (
    .clk        (clk),
    .clr        (clr),
    .count      (count),
    .evt_in     (evt_in),
    .edge_sel   (edge_sel),
    .cap_ready  (cap_ready),
    .ovf_clr    (ovf_clr),
    .cap_valid  (cap_valid),
    .cap_data   (cap_data),
    .cap_edge   (cap_edge),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: queue of captured entries, sticky flag, and the history
  // of evt_in samples at past posedges. A change between the samples taken
  // 3 and 2 posedges ago is an edge; pushes allowed from the 4th posedge on.
  logic [N+1:0] mq[$];
  logic         m_ovf;
  int           m_k;
  logic         h1, h2, h3;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_k   = 0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    end else begin : mdl
      logic m_rise, m_fall, m_push, m_drop;
      m_k    = (m_k < 4) ? m_k + 1 : 4;
      m_rise = h2 & ~h3;
      m_fall = ~h2 & h3;
      m_push = (m_k >= 4) && ((m_rise && edge_sel[0]) || (m_fall && edge_sel[1]));
      m_drop = 1'b0;
      if (mq.size() > 0 && cap_ready) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back({m_rise, count});
        else m_drop = 1'b1;
      end
      m_ovf = m_drop ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
      h3 = h2; h2 = h1; h1 = evt_in;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!clr) begin
      chk("cap_valid", int'(cap_valid), int'(mq.size() > 0));
      chk("fifo_level", int'(fifo_level), mq.size());
      chk("overflow", int'(overflow), int'(m_ovf));
      if (mq.size() > 0) begin
        chk("cap_data", int'(cap_data), int'(mq[0][N:0]));
        chk("cap_edge", int'(cap_edge), int'(mq[0][N+1]));
      end
    end
  end

  // Inputs change 2 time units after each posedge; count mimics a running counter.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      count = count + 1'b1;
    end
  endtask

  task automatic pop1();
    cap_ready = 1'b1;
    tick(1);
    cap_ready = 1'b0;
  endtask

  initial begin
    // Reset with evt_in held high
    evt_in = 1'b1;
    edge_sel = 2'b01;
    tick(2);
    chk("rst_cap_valid", int'(cap_valid), 0);
    chk("rst_cap_data", int'(cap_data), 0);
    chk("rst_cap_edge", int'(cap_edge), 0);
    chk("rst_fifo_level", int'(fifo_level), 0);
    chk("rst_overflow", int'(overflow), 0);
    clr = 1'b0;

    // 1: no false capture after release with evt_in high
    tick(20);
    chk("t1_no_capture", int'(cap_valid), 0);
    chk("t1_model_empty", mq.size(), 0);

    // 2: single rising edge, count 8'h10 at the detect posedge
    evt_in = 1'b0;
    tick(4);
    evt_in = 1'b1;
    count = 8'h0E;
    tick(3);
    chk("t2_cap_valid", int'(cap_valid), 1);
    chk("t2_cap_data", int'(cap_data), 'h10);
    chk("t2_cap_edge", int'(cap_edge), 1);
    chk("t2_fifo_level", int'(fifo_level), 1);
    pop1();
    chk("t2_drained", int'(fifo_level), 0);

    // 3: both edges, 5-cycle pulse
    evt_in = 1'b0;
    tick(4);
    edge_sel = 2'b11;
    evt_in = 1'b1;
    count = 8'h20;
    tick(5);
    evt_in = 1'b0;
    tick(6);
    chk("t3_level", int'(fifo_level), 2);
    chk("t3_first_data", int'(cap_data), 'h22);
    chk("t3_first_edge", int'(cap_edge), 1);
    pop1();
    chk("t3_second_data", int'(cap_data), 'h27);
    chk("t3_second_edge", int'(cap_edge), 0);
    pop1();
    chk("t3_empty", int'(cap_valid), 0);

    // 4: five rising edges into a 4-deep FIFO with no drain
    edge_sel = 2'b01;
    count = 8'h40;
    for (int i = 0; i < 5; i++) begin
      evt_in = 1'b1;
      tick(2);
      evt_in = 1'b0;
      tick(2);
    end
    chk("t4_level_full", int'(fifo_level), 4);
    chk("t4_overflow", int'(overflow), 1);
    chk("t4_head", int'(cap_data), 'h42);
    chk("t4_model_tail", int'(mq[3][N:0]), 'h4E);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("t4_ovf_cleared", int'(overflow), 0);
    // drop coinciding with ovf_clr: set wins
    evt_in = 1'b1;
    tick(2);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("t4_set_wins", int'(overflow), 1);
    chk("t4_level_kept", int'(fifo_level), 4);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("t4_ovf_cleared2", int'(overflow), 0);

    // 5: full FIFO, push and pop on the same edge
    evt_in = 1'b0;
    tick(3);
    evt_in = 1'b1;
    count = 8'h60;
    tick(2);
    cap_ready = 1'b1;
    tick(1);
    cap_ready = 1'b0;
    chk("t5_level", int'(fifo_level), 4);
    chk("t5_overflow", int'(overflow), 0);
    chk("t5_head", int'(cap_data), 'h46);
    chk("t5_model_tail", int'(mq[3][N:0]), 'h62);
    pop1();
    chk("t5_head2", int'(cap_data), 'h4A);
    chk("t5_level3", int'(fifo_level), 3);

    // 6: asynchronous clear mid-operation
    clr = 1'b1;
    #1;
    chk("t6_async_valid", int'(cap_valid), 0);
    chk("t6_async_level", int'(fifo_level), 0);
    tick(1);
    clr = 1'b0;
    tick(10);
    chk("t6_warmup_ignored", int'(fifo_level), 0);

    // counter wrap: FF -> 00 captured as-is
    evt_in = 1'b0;
    tick(4);
    evt_in = 1'b1;
    count = 8'hFE;
    tick(3);
    chk("wrap_valid", int'(cap_valid), 1);
    chk("wrap_data", int'(cap_data), 'h00);
    chk("wrap_edge", int'(cap_edge), 1);

    // edge_sel off: nothing captured; ready on empty FIFO is harmless
    cap_ready = 1'b1;
    edge_sel = 2'b00;
    evt_in = 1'b0;
    tick(4);
    evt_in = 1'b1;
    tick(4);
    cap_ready = 1'b0;
    chk("off_no_capture", int'(fifo_level), 0);

    // falling-only capture
    edge_sel = 2'b10;
    evt_in = 1'b0;
    count = 8'h80;
    tick(3);
    chk("fall_data", int'(cap_data), 'h82);
    chk("fall_edge", int'(cap_edge), 0);
    chk("fall_level", int'(fifo_level), 1);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
